// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD subtractor.
package bcd_pkg;
    localparam int BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SUB,
        ST_NEG,
        ST_DONE
    } state_t;
endpackage

// File: rtl/bcd_subtractor_serial_if.sv
// Operand/result bundle for the serial BCD subtractor.
interface bcd_subtractor_serial_if #(parameter int DIGITS = 4);
    import bcd_pkg::*;

    logic                          start;
    logic [BCD_DIGIT_W*DIGITS-1:0] A;
    logic [BCD_DIGIT_W*DIGITS-1:0] B;
    logic [BCD_DIGIT_W*DIGITS-1:0] F;
    logic                          Neg;
    logic                          Err;
    logic                          Busy;
    logic                          Done;

    modport master (output start, A, B, input F, Neg, Err, Busy, Done);
    modport slave  (input start, A, B, output F, Neg, Err, Busy, Done);
endinterface

// File: rtl/bcd_digit_sub.sv
// One BCD digit of x - y - bin with decimal borrow correction.
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] x,
    input  logic [BCD_DIGIT_W-1:0] y,
    input  logic                   bin,
    output logic [BCD_DIGIT_W-1:0] d,
    output logic                   bout
);
    logic [BCD_DIGIT_W:0] t;

    // Operands are <= 9, so t spans -10..9 and its top bit is the sign.
    always_comb begin
        t    = {1'b0, x} - {1'b0, y} - {{BCD_DIGIT_W{1'b0}}, bin};
        bout = t[BCD_DIGIT_W];
        d    = bout ? t[BCD_DIGIT_W-1:0] + BCD_DIGIT_W'(10) : t[BCD_DIGIT_W-1:0];
    end
endmodule

// File: rtl/bcd_subtractor_serial.sv
// Digit-serial BCD subtractor: A-B LSD first, then a ten's-complement pass
// (NEG) when the result went negative, giving |A-B| with a sign flag.
module bcd_subtractor_serial
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input logic                     clk,
    input logic                     rst_n,
    bcd_subtractor_serial_if.slave  bus
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef logic [DIGITS-1:0][BCD_DIGIT_W-1:0] word_t;

    state_t  state, nstate;
    word_t   a_in, b_in, a_q, b_q, w_q, w_nxt, f_q;
    logic [IW-1:0] idx;
    logic    borrow, neg_q, err_q, bad_in, last;
    logic [BCD_DIGIT_W-1:0] x, y, d;
    logic    bout;

    assign a_in = word_t'(bus.A);
    assign b_in = word_t'(bus.B);
    assign last = (idx == LAST);

    always_comb begin
        bad_in = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (a_in[i] > BCD_MAX || b_in[i] > BCD_MAX) bad_in = 1'b1;
    end

    // Single digit slice shared by both passes; NEG computes 0 - W_k - borrow.
    always_comb begin
        x = a_q[idx];
        y = b_q[idx];
        if (state == ST_NEG) begin
            x = '0;
            y = w_q[idx];
        end
    end

    bcd_digit_sub u_dsub (
        .x    (x),
        .y    (y),
        .bin  (borrow),
        .d    (d),
        .bout (bout)
    );

    always_comb begin
        w_nxt = w_q;
        if (state == ST_SUB || state == ST_NEG) w_nxt[idx] = d;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= nstate;
    end

    // Next-state logic
    always_comb begin
        nstate = state;
        case (state)
            ST_IDLE: if (bus.start) nstate = bad_in ? ST_DONE : ST_SUB;
            ST_SUB:  if (last)      nstate = bout ? ST_NEG : ST_DONE;
            ST_NEG:  if (last)      nstate = ST_DONE;
            ST_DONE:                nstate = ST_IDLE;
            default:                nstate = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.Busy = (state != ST_IDLE);
        bus.Done = (state == ST_DONE);
        bus.F    = f_q;
        bus.Neg  = neg_q;
        bus.Err  = err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            w_q    <= '0;
            idx    <= '0;
            borrow <= 1'b0;
            f_q    <= '0;
            neg_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (bus.start) begin
                    a_q    <= a_in;
                    b_q    <= b_in;
                    w_q    <= '0;
                    idx    <= '0;
                    borrow <= 1'b0;
                end
                ST_SUB, ST_NEG: begin
                    w_q <= w_nxt;
                    if (last) begin
                        idx    <= '0;
                        borrow <= 1'b0;
                    end else begin
                        idx    <= idx + 1'b1;
                        borrow <= bout;
                    end
                end
                default: ;
            endcase
            // Results latch only on DONE entry; IDLE->DONE is the error path.
            if (nstate == ST_DONE && state != ST_DONE) begin
                f_q   <= (state == ST_IDLE) ? '0 : w_nxt;
                neg_q <= (state == ST_NEG);
                err_q <= (state == ST_IDLE);
            end
        end
    end
endmodule

// File: tb/tb_bcd_subtractor_serial.sv
// Scoreboard bench: stimulus pushes expected results, a monitor checks each Done.
module tb_bcd_subtractor_serial;
    localparam int D = 4;

    typedef struct {
        logic [15:0] f;
        logic        neg;
        logic        err;
        int          drv;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sbq[$];

    bcd_subtractor_serial_if #(.DIGITS(D)) bus ();

    bcd_subtractor_serial #(.DIGITS(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.Done) begin
            if (sbq.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                check("F",       32'(bus.F),   32'(e.f));
                check("Neg",     32'(bus.Neg), 32'(e.neg));
                check("Err",     32'(bus.Err), 32'(e.err));
                check("latency", 32'(cyc - e.drv), 32'(e.lat));
            end
        end
    end

    task automatic push(input logic [15:0] f, input logic neg, input logic err,
                        input int drv, input int lat);
        exp_t e;
        e.f = f; e.neg = neg; e.err = err; e.drv = drv; e.lat = lat;
        sbq.push_back(e);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.Busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check("idle_timeout", 32'd1, 32'd0);
    endtask

    // One start pulse; expectation pushed with the cycle start is driven in.
    task automatic op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] f,
                      input logic neg, input logic err, input int lat);
        wait_idle();
        @(posedge clk); #1;
        bus.A = a; bus.B = b; bus.start = 1'b1;
        push(f, neg, err, cyc, lat);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    initial begin
        int c0;
        int n;
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_F",    32'(bus.F),    32'd0);
        check("rst_Neg",  32'(bus.Neg),  32'd0);
        check("rst_Err",  32'(bus.Err),  32'd0);
        check("rst_Busy", 32'(bus.Busy), 32'd0);
        check("rst_Done", 32'(bus.Done), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        op(16'h0042, 16'h0017, 16'h0025, 1'b0, 1'b0, D + 1);
        op(16'h0017, 16'h0042, 16'h0025, 1'b1, 1'b0, 2 * D + 1);
        op(16'h0000, 16'h0001, 16'h0001, 1'b1, 1'b0, 2 * D + 1);
        op(16'h9999, 16'h9999, 16'h0000, 1'b0, 1'b0, D + 1);
        op(16'h00A1, 16'h0003, 16'h0000, 1'b0, 1'b1, 1);
        op(16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0, D + 1);
        op(16'h0001, 16'h9999, 16'h9998, 1'b1, 1'b0, 2 * D + 1);
        op(16'h0003, 16'h00B0, 16'h0000, 1'b0, 1'b1, 1);

        // start re-pulsed mid-SUB with new operands must be ignored
        wait_idle();
        @(posedge clk); #1;
        bus.A = 16'h0042; bus.B = 16'h0017; bus.start = 1'b1;
        push(16'h0025, 1'b0, 1'b0, cyc, D + 1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.A = 16'h0017; bus.B = 16'h0042; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;

        // start held through DONE: second op accepted in the following IDLE cycle
        wait_idle();
        @(posedge clk); #1;
        bus.A = 16'h0042; bus.B = 16'h0017; bus.start = 1'b1;
        c0 = cyc;
        push(16'h0025, 1'b0, 1'b0, c0, D + 1);
        push(16'h0025, 1'b1, 1'b0, c0 + D + 2, 2 * D + 1);
        repeat (2) @(posedge clk);
        #1;
        bus.A = 16'h0017; bus.B = 16'h0042;
        repeat (8) @(posedge clk);
        #1;
        bus.start = 1'b0;

        // reset during NEG of 0017-0042 aborts with no Done
        wait_idle();
        @(posedge clk); #1;
        bus.A = 16'h0017; bus.B = 16'h0042; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.A = 16'h0000; bus.B = 16'h0000;
        repeat (D + 1) @(posedge clk);
        #1;
        check("pre_rst_Busy", 32'(bus.Busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_F",    32'(bus.F),    32'd0);
        check("abort_Neg",  32'(bus.Neg),  32'd0);
        check("abort_Err",  32'(bus.Err),  32'd0);
        check("abort_Busy", 32'(bus.Busy), 32'd0);
        check("abort_Done", 32'(bus.Done), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2 * D) @(posedge clk);
        #1;
        op(16'h0042, 16'h0017, 16'h0025, 1'b0, 1'b0, D + 1);

        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(sbq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bcd_subtractor_serial.md
BCD_SUBTRACTOR_SERIAL -- requirements
Module: bcd_subtractor_serial

Interface
REQ-001 Parameter DIGITS, default 4, number of BCD digits per operand (range 1..8).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 A  input  4*DIGITS  minuend, packed BCD, digit 0 in bits [3:0].
REQ-006 B  input  4*DIGITS  subtrahend, packed BCD, same packing.
REQ-007 F  output  4*DIGITS  magnitude |A-B|, packed BCD.
REQ-008 Neg  output  1  1 when A < B.
REQ-009 Err  output  1  1 when any A or B digit > 9 at capture.
REQ-010 Busy  output  1  operation in progress.
REQ-011 Done  output  1  one-cycle result-valid pulse.

Function
REQ-012 States: IDLE, SUB, NEG, DONE; one digit is processed per cycle in SUB and in NEG.
REQ-013 In IDLE with start=1, the block SHALL capture A and B, clear the digit index and borrow, then go to SUB; if any captured digit > 9, it SHALL go to DONE instead.
REQ-014 Each SUB cycle k (0..DIGITS-1, LSD first): d = A_k - B_k - borrow; if d < 0 then d += 10 and borrow = 1, else borrow = 0; store d in working digit k.
REQ-015 After digit DIGITS-1, SUB SHALL go to DONE if the final borrow = 0, else to NEG with the index and borrow cleared.
REQ-016 Each NEG cycle k: working digit k = 0 - W_k - borrow, with the same +10 correction, so that the working value becomes 10^DIGITS - W, which equals B - A.
REQ-017 After digit DIGITS-1, NEG SHALL go to DONE.
REQ-018 DONE lasts one cycle with Done=1, then returns to IDLE.
REQ-019 F, Neg and Err SHALL update only on entry to DONE and hold until the next DONE.
REQ-020 On error, F=0, Neg=0, Err=1; otherwise Err=0.
REQ-021 Latency from the start-sampling edge to Done=1 SHALL be DIGITS+1 cycles (A ≥ B), 2*DIGITS+1 cycles (A < B), or 1 cycle (Err).
REQ-022 Busy SHALL be 1 in SUB, NEG and DONE; start SHALL be ignored while Busy=1.
REQ-023 A and B changing after capture SHALL NOT affect the result.
REQ-024 A = B SHALL give F=0, Neg=0 with no NEG pass.
REQ-025 Back-to-back operations: start held high through DONE SHALL be accepted in the following IDLE cycle.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, F=0, Neg=0, Err=0, Busy=0, Done=0, and clear the working register, index and borrow.
REQ-027 Reset asserted mid-operation SHALL abort it with no Done pulse; the first start after release SHALL behave as from power-up.

Structure
REQ-028 Shared package bcd_pkg SHALL hold the state typedef, BCD_DIGIT_W=4, and BCD_MAX=9.
REQ-029 One sub-module, bcd_digit_sub (combinational: x, y, bin -> d, bout with the +10 correction), SHALL be instantiated once and shared by SUB and NEG.
REQ-030 The digit index width SHALL be clog2(DIGITS), minimum 1.

Verification
REQ-031 A=0042, B=0017, start -> F=0025, Neg=0, Err=0, Done 5 cycles after start.
REQ-032 A=0017, B=0042 -> F=0025, Neg=1, Done 9 cycles after start.
REQ-033 A=0000, B=0001 -> F=0001, Neg=1; A=9999, B=9999 -> F=0000, Neg=0.
REQ-034 A=00A1, B=0003 -> Err=1, F=0000, Neg=0, Done 1 cycle after start.
REQ-035 start pulsed in cycle 2 of SUB with new operands -> ignored; the first result is unchanged and only one Done pulse occurs.
REQ-036 rst_n low during NEG of 0017-0042 -> outputs zero at once, no Done; then 0042-0017 -> F=0025.
